// File: rtl/blinking_pwm.sv
// blinking_pwm: self-timed PWM LED driver with frame-by-frame high length sweep (optional BLINKING_PWM_BREATHE_EN)
module blinking_pwm #(
  parameter int MAX_N     = 8,
  parameter int LOW_RATIO = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pwm_out
);
  localparam int CW = $clog2(LOW_RATIO * MAX_N + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MX  = CW'(MAX_N);
  localparam logic [CW-1:0] LR  = CW'(LOW_RATIO);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state;
  logic [CW-1:0] n, cnt, n_next;
`ifdef BLINKING_PWM_BREATHE_EN
  logic dir, dir_next;
  // triangle sweep: turn around at both endpoints, dir=1 means counting down
  always_comb begin
    n_next   = (MAX_N == 1) ? n : (dir ? ((n == ONE) ? n + ONE : n - ONE) : ((n == MX) ? n - ONE : n + ONE));
    dir_next = (MAX_N == 1) ? dir : (dir ? (n != ONE) : (n == MX));
  end
`else
  // sawtooth sweep: wrap to 1 after the longest frame
  always_comb n_next = (n == MX) ? ONE : n + ONE;
`endif
  // frame sequencer; abort on en low mid-frame shares the reset path
  always_ff @(posedge clk) begin
    if (rst || (state != IDLE && !en)) begin
      state   <= IDLE;
      pwm_out <= 1'b0;
      n       <= ONE;
      cnt     <= '0;
`ifdef BLINKING_PWM_BREATHE_EN
      dir     <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (en) begin
        state   <= HIGH;
        pwm_out <= 1'b1;
        cnt     <= ONE;
      end
    end else if (state == HIGH) begin
      if (cnt == n) begin
        state   <= LOW;
        pwm_out <= 1'b0;
        cnt     <= ONE;
      end else cnt <= cnt + ONE;
    end else begin
      if (cnt == LR * n) begin
        state   <= HIGH;
        pwm_out <= 1'b1;
        cnt     <= ONE;
        n       <= n_next;
`ifdef BLINKING_PWM_BREATHE_EN
        dir     <= dir_next;
`endif
      end else cnt <= cnt + ONE;
    end
  end
endmodule

// File: tb/tb_blinking_pwm.sv
// tb_blinking_pwm: scoreboard bench for blinking_pwm over default, MAX_N=3 and square-wave configurations
module tb_blinking_pwm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic pwm_d, pwm_3, pwm_1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_d[$], sb_3[$], sb_1[$];
  bit pd[$], p3[$], p1[$];

  blinking_pwm #(.MAX_N(8), .LOW_RATIO(2)) u_def (.clk(clk), .rst(rst), .en(en), .pwm_out(pwm_d));
  blinking_pwm #(.MAX_N(3), .LOW_RATIO(2)) u_n3  (.clk(clk), .rst(rst), .en(en), .pwm_out(pwm_3));
  blinking_pwm #(.MAX_N(1), .LOW_RATIO(1)) u_sq  (.clk(clk), .rst(rst), .en(en), .pwm_out(pwm_1));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic got, input bit exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, got, exp);
    end
  endtask

  // monitor: one expected value per DUT per edge, popped just after the edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sb_d.size() > 0) cmp("pwm_def", pwm_d, sb_d.pop_front());
    if (sb_3.size() > 0) cmp("pwm_n3", pwm_3, sb_3.pop_front());
    if (sb_1.size() > 0) cmp("pwm_sq", pwm_1, sb_1.pop_front());
  end

  task automatic step(input logic r, input logic e, input bit bd, input bit b3, input bit b1);
    @(negedge clk);
    rst = r;
    en  = e;
    sb_d.push_back(bd);
    sb_3.push_back(b3);
    sb_1.push_back(b1);
  endtask

  task automatic add_frame(input int id, input int n, input int lr);
    for (int i = 0; i < n * (1 + lr); i++) begin
      if (id == 0) pd.push_back(i < n);
      else if (id == 3) p3.push_back(i < n);
      else p1.push_back(i < n);
    end
  endtask

  task automatic run(input int len);
    for (int i = 0; i < len; i++) step(1'b0, 1'b1, pd[i], p3[i], p1[i]);
    pd.delete();
    p3.delete();
    p1.delete();
  endtask

  initial begin
`ifdef BLINKING_PWM_BREATHE_EN
    int seq3[6] = '{1, 2, 3, 2, 1, 2};
`else
    int seq3[6] = '{1, 2, 3, 1, 2, 3};
`endif
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      add_frame(0, n, 2);
      add_frame(3, n, 2);
    end
    for (int i = 0; i < 6; i++) add_frame(1, 1, 1);
    run(11);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 5; n++) add_frame(0, n, 2);
    for (int i = 0; i < 6; i++) add_frame(3, seq3[i], 2);
    for (int i = 0; i < 17; i++) add_frame(1, 1, 1);
    run(33);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_d.size() + sb_3.size() + sb_1.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sb_d.size() + sb_3.size() + sb_1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/blinking_pwm.md
# blinking_pwm

Self-timed blinking/breathing LED driver producing one PWM output whose pulse widths change frame by frame.
- Each frame is N cycles high followed by LOW_RATIO·N cycles low.
- N steps 1, 2, 3, … up to MAX_N, then (with breathing compiled in) back down to 1, and repeats.
- Sits at the end of a status/indicator chain and drives an LED pin or pad buffer directly.
- Needs no register interface; only an enable.

## Interface
- MAX_N, default 8 — maximum high-phase length in cycles; legal range 1 to 255.
- LOW_RATIO, default 2 — low-phase multiplier (low = LOW_RATIO·N cycles); legal range 1 to 15.
- clk  input  1  — single clock; all logic on its rising edge.
- rst  input  1  — synchronous, active-high reset.
- en  input  1  — run enable, sampled on every rising edge.
- pwm_out  output  1  — registered PWM output, high = LED on.

## Operation
- States:
  - IDLE: pwm_out = 0.
  - HIGH: pwm_out = 1.
  - LOW: pwm_out = 0.
- Internal registers:
  - n: current high length, range 1..MAX_N.
  - dir: up/down, used only with breathing enabled.
  - cnt: phase counter, width $clog2(LOW_RATIO·MAX_N+1).
- Reset (rst = 1 at an edge) puts the block in IDLE with pwm_out = 0, n = 1, dir = up, cnt = 0. Reset has priority over en.
- IDLE → HIGH at an edge where en = 1; cnt loads 1.
- HIGH: cnt increments each cycle. When cnt = n, go to LOW with cnt = 1.
- LOW: cnt increments each cycle. When cnt = LOW_RATIO·n, the frame ends: update n, then go to HIGH with cnt = 1.
- Updating n at frame end:
  - Up direction: n+1. If n = MAX_N, switch dir to down and use n−1 instead (breathing build only).
  - Down direction: n−1. If n = 1, switch dir to up and use n+1 instead.
- MAX_N = 1: n stays 1 permanently.
- Comparison arithmetic uses the unsigned cnt width. The product LOW_RATIO·n is formed at that same width with no overflow, which the legal parameter ranges guarantee.
- en = 0 at any edge in HIGH or LOW aborts the sequence:
  - next state IDLE, pwm_out = 0;
  - n = 1, dir = up, cnt = 0.
  - Re-enabling restarts at n = 1.
- en toggling inside a frame: each edge with en = 0 aborts as above; there is no hysteresis.

## Timing
- pwm_out is a flop output with no combinational path from en.
- Sampling en = 1 at edge k (from IDLE) drives pwm_out = 1 immediately after edge k.
- Frame with high length n:
  - pwm_out is high for exactly n cycles;
  - then low for exactly LOW_RATIO·n cycles;
  - the next frame's high starts at edge k + (1+LOW_RATIO)·n.
- No gap cycles between frames; total frame length is (1+LOW_RATIO)·n.
- With defaults, frames N = 1..3 occupy 3, 6 and 9 cycles, so the first high pulses start at relative edges 0, 3 and 9.
- Reset and abort both take effect on the same edge: pwm_out is 0 after that edge.

## Configuration
- BLINKING_PWM_BREATHE_EN defined:
  - triangle sweep 1→MAX_N→1→…, with each endpoint visited once per sweep;
  - example for MAX_N = 3: 1, 2, 3, 2, 1, 2, 3, …
- BLINKING_PWM_BREATHE_EN undefined:
  - sawtooth sweep; after the MAX_N frame, n wraps to 1;
  - the dir register is removed;
  - example for MAX_N = 3: 1, 2, 3, 1, 2, 3, …

## Test plan
- Reset hold: rst = 1 for 3 cycles with en = 1 → pwm_out = 0 throughout; release rst, en sampled at the next edge → pwm_out high after that edge.
- First frames (defaults): enable from IDLE → high 1 / low 2, then high 2 / low 4, then high 3 / low 6, checked cycle-exact.
- Breathing turnaround (MAX_N = 3, macro defined) → high lengths 1, 2, 3, 2, 1, 2 with lows 2, 4, 6, 4, 2, 4.
- Sawtooth (MAX_N = 3, macro undefined) → high lengths 1, 2, 3, 1, 2.
- Abort: drop en in the middle of the N = 3 high phase → pwm_out = 0 on that edge; re-enable → next frame is high 1 / low 2.
- LOW_RATIO = 1, MAX_N = 1 → continuous 1-high/1-low square wave with period 2 cycles.
